// File: rtl/decode_pipe_stage_if.sv
// Fetch-to-decode handshake plus the registered decode bundle consumed by execute.
interface decode_pipe_stage_if #(
   parameter int N = 32
);
   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_inst;
   logic [N-1:0]  if_pc;

   logic          id_valid;
   logic [2:0]    id_cond;
   logic [1:0]    id_op;
   logic          id_imm_flag;
   logic [4:0]    id_cmd;
   logic [3:0]    id_rd;
   logic [3:0]    id_a1;
   logic [3:0]    id_a2;
   logic [N-1:0]  id_rd1;
   logic [N-1:0]  id_rd2;
   logic [N-1:0]  id_imm_ext;

   modport master (
      output if_valid, if_inst, if_pc,
      input  if_ready,
      input  id_valid, id_cond, id_op, id_imm_flag, id_cmd, id_rd,
      input  id_a1, id_a2, id_rd1, id_rd2, id_imm_ext
   );

   modport slave (
      input  if_valid, if_inst, if_pc,
      output if_ready,
      output id_valid, id_cond, id_op, id_imm_flag, id_cmd, id_rd,
      output id_a1, id_a2, id_rd1, id_rd2, id_imm_ext
   );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode stage with IF/ID register, 16-entry regfile (write bypass, PC substitution), imm extend.
// One-cycle latency; stall holds ID, flush kills it, a load-use dependency inserts one bubble.
module decode_pipe_stage #(
   parameter int N         = 32,
   parameter int PC_REG    = 15,
   parameter int PC_OFFSET = 8
) (
   input  logic          clk,
   input  logic          reset,
   decode_pipe_stage_if.slave bus,
   input  logic          stall_in,
   input  logic          flush,
   input  logic          reg_src_a1,
   input  logic          reg_src_a2,
   input  logic          wb_en,
   input  logic [3:0]    wb_addr,
   input  logic [N-1:0]  wb_data,
   output logic          hazard,
   output logic [N-1:0]  dbg_r0,
   output logic [N-1:0]  dbg_r1
);
   localparam logic [3:0] PC_IDX = 4'(PC_REG);

   typedef struct packed {
      logic [2:0]    cond;
      logic [1:0]    op;
      logic          imm_flag;
      logic [4:0]    cmd;
      logic [3:0]    rd;
      logic [3:0]    a1;
      logic [3:0]    a2;
      logic [N-1:0]  rd1;
      logic [N-1:0]  rd2;
      logic [N-1:0]  imm_ext;
      logic          is_load;
   } id_t;

   logic [N-1:0] rf_q [16];
   logic [N-1:0] rf_d [16];
   id_t          id_q, id_d, dec;
   logic         id_valid_q, id_valid_d;

   logic [3:0]   rn, rs;
   logic [N-1:0] pc_rd;
   logic [63:0]  br_ext, zx_ext;

   // Writes to the PC alias are dropped so that entry stays at zero forever.
   always_comb begin
      rf_d = rf_q;
      if (wb_en && wb_addr != PC_IDX) begin
         rf_d[wb_addr] = wb_data;
      end
   end

   always_comb begin
      dec          = '0;
      dec.cond     = bus.if_inst[31:29];
      dec.op       = bus.if_inst[28:27];
      dec.imm_flag = bus.if_inst[26];
      dec.cmd      = bus.if_inst[25:21];
      dec.rd       = bus.if_inst[20:17];
      rn           = bus.if_inst[16:13];
      rs           = bus.if_inst[3:0];
      dec.a1       = reg_src_a1 ? PC_IDX : rn;
      dec.a2       = reg_src_a2 ? dec.rd : rs;
      dec.is_load  = (dec.op == 2'b01) && dec.cmd[0];

      pc_rd  = bus.if_pc + N'(PC_OFFSET);
      dec.rd1 = (dec.a1 == PC_IDX)                 ? pc_rd   :
                (wb_en && wb_addr == dec.a1)       ? wb_data : rf_q[dec.a1];
      dec.rd2 = (dec.a2 == PC_IDX)                 ? pc_rd   :
                (wb_en && wb_addr == dec.a2)       ? wb_data : rf_q[dec.a2];

      br_ext = {{38{bus.if_inst[23]}}, bus.if_inst[23:0], 2'b00};
      zx_ext = {51'b0, bus.if_inst[12:0]};
      if (dec.op == 2'b10) begin
         dec.imm_ext = br_ext[N-1:0];
      end else if (dec.imm_flag) begin
         dec.imm_ext = zx_ext[N-1:0];
      end else begin
         dec.imm_ext = '0;
      end
   end

   assign hazard = bus.if_valid && id_valid_q && id_q.is_load && !flush &&
                   (id_q.rd == dec.a1 || id_q.rd == dec.a2) && id_q.rd != PC_IDX;

   assign bus.if_ready = !reset && (flush || (!stall_in && !hazard));

   always_comb begin
      id_d       = id_q;
      id_valid_d = id_valid_q;
      if (flush) begin
         id_valid_d = 1'b0;
      end else if (stall_in) begin
         id_valid_d = id_valid_q;
      end else if (hazard) begin
         id_valid_d = 1'b0;
      end else if (bus.if_valid) begin
         id_d       = dec;
         id_valid_d = 1'b1;
      end else begin
         id_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= '0;
         end
         id_q       <= '0;
         id_valid_q <= 1'b0;
      end else begin
         rf_q       <= rf_d;
         id_q       <= id_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign bus.id_valid    = id_valid_q;
   assign bus.id_cond     = id_q.cond;
   assign bus.id_op       = id_q.op;
   assign bus.id_imm_flag = id_q.imm_flag;
   assign bus.id_cmd      = id_q.cmd;
   assign bus.id_rd       = id_q.rd;
   assign bus.id_a1       = id_q.a1;
   assign bus.id_a2       = id_q.a2;
   assign bus.id_rd1      = id_q.rd1;
   assign bus.id_rd2      = id_q.rd2;
   assign bus.id_imm_ext  = id_q.imm_ext;
   assign dbg_r0          = rf_q[0];
   assign dbg_r1          = rf_q[1];
endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage: reset, bypass, PC read, immediates, load-use, stall/flush.
module tb_decode_pipe_stage;
   logic        clk = 1'b0;
   logic        reset, stall_in, flush, reg_src_a1, reg_src_a2, wb_en, hazard;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data, dbg_r0, dbg_r1;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   decode_pipe_stage_if #(.N(32)) bus ();

   decode_pipe_stage #(.N(32), .PC_REG(15), .PC_OFFSET(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .stall_in   (stall_in),
      .flush      (flush),
      .reg_src_a1 (reg_src_a1),
      .reg_src_a2 (reg_src_a2),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .hazard     (hazard),
      .dbg_r0     (dbg_r0),
      .dbg_r1     (dbg_r1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [1:0] op, input logic imm, input logic [4:0] cmd,
                                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rs);
      return {3'b101, op, imm, cmd, rd, rn, 9'b0, rs};
   endfunction

   initial begin
      reset = 1'b1; stall_in = 1'b0; flush = 1'b0; reg_src_a1 = 1'b0; reg_src_a2 = 1'b0;
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'hFFFF;
      bus.if_valid = 1'b1; bus.if_inst = mk(2'b01, 1'b1, 5'd1, 4'd4, 4'd1, 4'd1); bus.if_pc = 32'h100;
      step(); step();
      check("rst_valid", 32'(bus.id_valid), 32'h0);
      check("rst_rd", 32'(bus.id_rd), 32'h0);
      check("rst_cond", 32'(bus.id_cond), 32'h0);
      check("rst_rd1", bus.id_rd1, 32'h0);
      check("rst_imm", bus.id_imm_ext, 32'h0);
      check("rst_ready", 32'(bus.if_ready), 32'h0);
      check("rst_r1", dbg_r1, 32'h0);

      reset = 1'b0; bus.if_valid = 1'b0; wb_addr = 4'd3; wb_data = 32'hA5A5;
      #1 check("ready_idle", 32'(bus.if_ready), 32'h1);
      step();
      check("idle_valid", 32'(bus.id_valid), 32'h0);

      wb_addr = 4'd1; wb_data = 32'hBEEF;
      bus.if_valid = 1'b1; bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd2, 4'd3, 4'd3);
      step();
      check("r3_valid", 32'(bus.id_valid), 32'h1);
      check("r3_rd1", bus.id_rd1, 32'hA5A5);
      check("r3_rd2", bus.id_rd2, 32'hA5A5);
      check("r3_a1", 32'(bus.id_a1), 32'h3);
      check("r3_rd", 32'(bus.id_rd), 32'h2);
      check("r3_cond", 32'(bus.id_cond), 32'h5);
      check("dbg_r1", dbg_r1, 32'hBEEF);

      wb_addr = 4'd3; wb_data = 32'h1234;
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd2, 4'd3, 4'd1);
      step();
      check("byp_rd1", bus.id_rd1, 32'h1234);
      check("byp_rd2", bus.id_rd2, 32'hBEEF);
      check("byp_valid", 32'(bus.id_valid), 32'h1);

      reg_src_a1 = 1'b1; wb_addr = 4'd15; wb_data = 32'hFFFF;
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd2, 4'd3, 4'd3);
      step();
      check("pc_a1", 32'(bus.id_a1), 32'hF);
      check("pc_rd1", bus.id_rd1, 32'h108);
      check("pc_rd2_r3", bus.id_rd2, 32'h1234);

      reg_src_a2 = 1'b1; bus.if_pc = 32'h200; wb_addr = 4'd0; wb_data = 32'h0F0F;
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd15, 4'd3, 4'd3);
      step();
      check("pc_after_wr_rd1", bus.id_rd1, 32'h208);
      check("pc_rd_as_a2", bus.id_rd2, 32'h208);
      check("pc_a2", 32'(bus.id_a2), 32'hF);
      check("dbg_r0", dbg_r0, 32'h0F0F);

      wb_en = 1'b0; reg_src_a1 = 1'b0; reg_src_a2 = 1'b0;
      bus.if_inst = {3'b000, 2'b10, 1'b0, 2'b00, 24'hFFFFFE};
      step();
      check("imm_branch_neg", bus.id_imm_ext, 32'hFFFFFFF8);
      check("imm_branch_op", 32'(bus.id_op), 32'h2);
      bus.if_inst = {3'b000, 2'b10, 1'b1, 2'b00, 24'h000010};
      step();
      check("imm_branch_pos", bus.id_imm_ext, 32'h40);
      bus.if_inst = {3'b000, 2'b00, 1'b1, 5'd0, 4'd0, 4'd0, 13'h1FFF};
      step();
      check("imm_zext", bus.id_imm_ext, 32'h1FFF);
      check("imm_flag", 32'(bus.id_imm_flag), 32'h1);
      bus.if_inst = {3'b000, 2'b11, 1'b0, 5'd0, 4'd0, 4'd0, 13'h1FFF};
      step();
      check("imm_none", bus.id_imm_ext, 32'h0);

      bus.if_inst = mk(2'b01, 1'b0, 5'd1, 4'd5, 4'd0, 4'd0);
      #1 check("ld_no_haz", 32'(hazard), 32'h0);
      step();
      check("ld_valid", 32'(bus.id_valid), 32'h1);
      check("ld_rd", 32'(bus.id_rd), 32'h5);
      check("ld_cmd", 32'(bus.id_cmd), 32'h1);
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd6, 4'd5, 4'd0);
      #1 check("lu_hazard", 32'(hazard), 32'h1);
      check("lu_ready", 32'(bus.if_ready), 32'h0);
      step();
      check("bubble_valid", 32'(bus.id_valid), 32'h0);
      check("bubble_rd_hold", 32'(bus.id_rd), 32'h5);
      check("bubble_ready", 32'(bus.if_ready), 32'h1);
      step();
      check("dep_valid", 32'(bus.id_valid), 32'h1);
      check("dep_rd", 32'(bus.id_rd), 32'h6);
      check("dep_a1", 32'(bus.id_a1), 32'h5);

      bus.if_inst = mk(2'b01, 1'b0, 5'd1, 4'd15, 4'd0, 4'd0);
      step();
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd7, 4'd15, 4'd0);
      #1 check("ld_pcreg_no_haz", 32'(hazard), 32'h0);
      step();
      check("pcdep_rd", 32'(bus.id_rd), 32'h7);
      check("pcdep_rd1", bus.id_rd1, 32'h208);

      stall_in = 1'b1; bus.if_pc = 32'h300;
      bus.if_inst = mk(2'b00, 1'b0, 5'd0, 4'd9, 4'd1, 4'd1);
      wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'h7777;
      #1 check("stall_ready", 32'(bus.if_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_valid", 32'(bus.id_valid), 32'h1);
         check("stall_rd", 32'(bus.id_rd), 32'h7);
         check("stall_rd1", bus.id_rd1, 32'h208);
      end
      wb_en = 1'b0;
      flush = 1'b1;
      #1 check("flush_ready", 32'(bus.if_ready), 32'h1);
      step();
      check("flush_valid", 32'(bus.id_valid), 32'h0);
      flush = 1'b0; stall_in = 1'b0; bus.if_valid = 1'b0;
      step();
      check("post_flush_valid", 32'(bus.id_valid), 32'h0);

      bus.if_valid = 1'b1;
      step();
      check("pre_rst_valid", 32'(bus.id_valid), 32'h1);
      check("pre_rst_rd1", bus.id_rd1, 32'h7777);
      stall_in = 1'b1;
      step();
      reset = 1'b1;
      step();
      check("mid_rst_valid", 32'(bus.id_valid), 32'h0);
      check("mid_rst_rd", 32'(bus.id_rd), 32'h0);
      check("mid_rst_r1", dbg_r1, 32'h0);
      check("mid_rst_ready", 32'(bus.if_ready), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Parametrised decode stage with its own IF/ID pipeline register.
- Decodes the 32-bit instruction and reads a 16-entry register file with write-through bypass and PC-register substitution.
- Extends the immediate, detects load-use hazards, and supports stall, flush and bubble insertion.
- Sits between fetch and execute; the execute stage consumes the registered id_* outputs.

Parameters:
N, 32, register/data/PC width (>=16)
PC_REG, 15, register index that reads as PC+PC_OFFSET and ignores writes
PC_OFFSET, 8, value added to if_pc when PC_REG is read

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts if_inst this cycle
if_inst  in  32  instruction word
if_pc  in  N  PC of if_inst
stall_in  in  1  downstream stall; hold ID register
flush  in  1  discard ID register contents (branch taken)
reg_src_a1  in  1  1: A1=PC_REG, 0: A1=Rn
reg_src_a2  in  1  1: A2=Rd, 0: A2=Rs
wb_en  in  1  register write enable
wb_addr  in  4  write address
wb_data  in  N  write data
id_valid  out  1  ID register holds a live instruction
id_cond  out  3  inst[31:29]
id_op  out  2  inst[28:27]
id_imm_flag  out  1  inst[26]
id_cmd  out  5  inst[25:21]
id_rd  out  4  inst[20:17]
id_a1, id_a2  out  4 each  source addresses used
id_rd1, id_rd2  out  N each  source operands
id_imm_ext  out  N  extended immediate
hazard  out  1  load-use bubble inserted this cycle
dbg_r0, dbg_r1  out  N each  live contents of R0, R1

Behaviour:
- Field slicing: Rd=[20:17], Rn=[16:13], Rs=[3:0]; a1=reg_src_a1?PC_REG:Rn; a2=reg_src_a2?Rd:Rs.
- Immediate extension:
  - op==2'b10: sign-extend inst[23:0] shifted left 2.
  - op!=2'b10 and imm_flag=1: zero-extend inst[12:0].
  - Otherwise 0.
  - Result truncated or extended to N.
- Register file: 16xN.
  - Write at posedge when wb_en && wb_addr!=PC_REG && !reset.
  - Reads are combinational. Read of PC_REG returns if_pc+PC_OFFSET (mod 2^N).
  - Otherwise, if wb_en && wb_addr==addr, returns wb_data (bypass). Otherwise returns array content.
- Load detect: id_is_load (internal, registered) = (op==2'b01 && cmd[0]==1).
- hazard = if_valid && id_valid && id_is_load && !flush && (id_rd==a1 || id_rd==a2) && id_rd!=PC_REG.
- if_ready = !reset && (flush || (!stall_in && !hazard)).
- ID register update, priority order:
  1. reset: all id_* outputs, id_is_load and all 16 registers <= 0. if_ready=0.
  2. flush: id_valid<=0, other id_* don't-care (hold). A concurrent if_inst is accepted but dropped.
  3. stall_in: all id_* hold, including id_valid.
  4. hazard: id_valid<=0 (bubble), other fields hold. The fetch instruction is not accepted and is re-presented next cycle.
  5. if_valid: load all fields and operands, id_valid<=1.
  6. !if_valid: id_valid<=0.
- Latency: an instruction accepted at edge k appears on id_* after edge k (1 cycle). A load followed by a dependent instruction costs exactly 1 bubble.
- Operands are sampled at acceptance. A write landing later while the instruction stalls in ID is not reflected; forwarding from later stages is the execute stage's job.
- wb_addr==PC_REG writes are silently dropped. Reset mid-stall clears everything in one cycle.

Test Plan:
- reset=1 two cycles, then wb_en=1, wb_addr=3, wb_data=0xA5A5 -> after edge R3=0xA5A5. All id_* were 0 during reset.
- Bypass: if_inst Rn=3, wb write R3=0x1234 same cycle -> next cycle id_rd1=0x1234, id_valid=1.
- PC read: reg_src_a1=1, if_pc=0x100 -> id_rd1=0x108. wb write to R15=0xFFFF -> R15 still reads if_pc+8.
- Load-use: accept load (op=01, cmd[0]=1, Rd=5), next inst Rn=5 -> hazard=1, if_ready=0, id_valid=0 for 1 cycle. Dependent inst appears on id_* the following cycle.
- stall_in=1 for 3 cycles with id_valid=1 -> all id_* unchanged, if_ready=0. Then flush=1 with stall_in=1 -> id_valid=0 next cycle.
- Immediates: op=10, inst[23:0]=0xFFFFFE -> id_imm_ext=0xFFFFFFF8. op=00, imm_flag=1, inst[12:0]=0x1FFF -> 0x00001FFF.
